// File: rtl/mem_xfer_pkg.sv
// Shared types and defaults for the memoryA -> memoryB pair transfer controller.
package mem_xfer_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_A_W = 3;
  localparam int ADDR_B_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    CALC,
    WR,
    DONE
  } state_t;

  // Unsigned compare, then subtract or add modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] pair_combine(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
    if (a >= b) return a - b;
    else        return a + b;
  endfunction

endpackage

// File: rtl/xfer_pair_alu.sv
// Combines one memoryA pair: difference when opA >= opB, otherwise wrapping sum.
module xfer_pair_alu #(
  parameter int DATA_W = mem_xfer_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    if (opA >= opB) result = opA - opB;
    else            result = opA + opB;
  end

endmodule

// File: rtl/mem_xfer_ctrl.sv
// Reads memoryA in pairs, combines each pair, writes one word per pair into memoryB.
// States: IDLE wait start | RD0 addr even | RD1 addr odd, latch opA | CALC latch result | WR write B | DONE pulse
module mem_xfer_ctrl
  import mem_xfer_pkg::*;
#(
  parameter int DATA_W   = mem_xfer_pkg::DATA_W,
  parameter int ADDR_A_W = mem_xfer_pkg::ADDR_A_W,
  parameter int ADDR_B_W = mem_xfer_pkg::ADDR_B_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   DOut1,
  output logic [ADDR_A_W-1:0] AddrA,
  output logic [ADDR_B_W-1:0] AddrB,
  output logic                WEB,
  output logic [DATA_W-1:0]   DataInB,
  output logic                busy,
  output logic                done
);

  state_t              state, state_nx;
  logic [ADDR_B_W-1:0] k;
  logic [DATA_W-1:0]   opa_q;
  logic [DATA_W-1:0]   result;

  xfer_pair_alu #(.DATA_W(DATA_W)) u_alu (
    .opA    (opa_q),
    .opB    (DOut1),
    .result (result)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      k       <= '0;
      opa_q   <= '0;
      DataInB <= '0;
      AddrB   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) k <= '0;
        RD1:  opa_q <= DOut1;
        CALC: begin
          DataInB <= result;
          AddrB   <= k;
        end
        WR:   if (k != '1) k <= k + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs decode from state/k only, so reset clears them without waiting for a clock.
  always_comb begin
    state_nx = state;
    AddrA    = {k, 1'b0};
    WEB      = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RD0;
      RD0: begin
        busy     = 1'b1;
        state_nx = RD1;
      end
      RD1: begin
        busy     = 1'b1;
        AddrA    = {k, 1'b1};
        state_nx = CALC;
      end
      CALC: begin
        busy     = 1'b1;
        state_nx = WR;
      end
      WR: begin
        busy     = 1'b1;
        WEB      = 1'b1;
        state_nx = (k == '1) ? DONE : RD0;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Bench for mem_xfer_ctrl: memoryA/memoryB models, table of transfer vectors, write scoreboard.
module tb_mem_xfer_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] DOut1;
  logic [2:0] AddrA;
  logic [1:0] AddrB;
  logic       WEB;
  logic [7:0] DataInB;
  logic       busy;
  logic       done;

  always #5 clock = ~clock;

  mem_xfer_ctrl dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .DOut1   (DOut1),
    .AddrA   (AddrA),
    .AddrB   (AddrB),
    .WEB     (WEB),
    .DataInB (DataInB),
    .busy    (busy),
    .done    (done)
  );

  logic [7:0] mema [8];
  logic [7:0] memb [4];

  always @(posedge clock) begin
    DOut1 <= mema[busy ? AddrA : 3'd0];
    if (WEB) memb[AddrB] <= DataInB;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  typedef struct {
    logic [7:0] a [8];
    logic [7:0] b [4];
  } vec_t;

  wr_t  wq[$];
  int   dq[$];
  int   busy_cnt = 0;
  int   done_cnt = 0;
  vec_t vec [4];

  always @(negedge clock) begin
    wr_t e;
    if (!reset) begin
      if (WEB) begin
        if (wq.size() == 0) check("no_write_expected", WEB, 1'b0);
        else begin
          e = wq.pop_front();
          check("wr_addr", AddrB, e.addr);
          check("wr_data", DataInB, e.data);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        done_cnt++;
        if (dq.size() == 0) check("no_done_expected", done, 1'b0);
        else check("done_cycle", cyc, dq.pop_front());
      end
      if (busy) busy_cnt++;
    end
  end

  // t0 + n is the cyc value seen at the negedge of cycle n after the start-sampling edge.
  task automatic push_xfer(input int t0, input logic [7:0] b [4]);
    wr_t e;
    for (int i = 0; i < 4; i++) begin
      e.addr = 2'(i);
      e.data = b[i];
      e.cyc  = t0 + 4 * (i + 1);
      wq.push_back(e);
    end
    dq.push_back(t0 + 17);
  endtask

  task automatic pulse_start(output int t0);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    t0    = cyc - 1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((wq.size() != 0 || dq.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("drain_within_budget", (n < budget), 1'b1);
    repeat (3) @(negedge clock);
  endtask

  task automatic clear_b();
    for (int i = 0; i < 4; i++) memb[i] = 8'hAA;
  endtask

  task automatic check_b(input logic [7:0] b [4]);
    for (int i = 0; i < 4; i++) check($sformatf("memb[%0d]", i), memb[i], b[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    vec[0].a = '{8'hFF, 8'h00, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    vec[0].b = '{8'hFF, 8'h06, 8'h18, 8'h60};
    vec[1].a = '{8'hC0, 8'h80, 8'h80, 8'hC0, 8'h5A, 8'h5A, 8'h01, 8'h02};
    vec[1].b = '{8'h40, 8'h40, 8'h00, 8'h03};
    vec[2].a = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'hFF};
    vec[2].b = '{8'h00, 8'h00, 8'hFE, 8'h00};
    vec[3].a = '{8'h7F, 8'h80, 8'h10, 8'h0F, 8'h00, 8'h01, 8'hFE, 8'h03};
    vec[3].b = '{8'hFF, 8'h01, 8'h01, 8'hFB};

    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) mema[i] = 8'h00;
    clear_b();
    repeat (2) @(negedge clock);
    check("rst_AddrA", AddrA, 3'd0);
    check("rst_AddrB", AddrB, 2'd0);
    check("rst_WEB", WEB, 1'b0);
    check("rst_DataInB", DataInB, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Table-driven transfers
    for (int v = 0; v < 4; v++) begin
      mema = vec[v].a;
      clear_b();
      busy_cnt = 0;
      done_cnt = 0;
      pulse_start(t0);
      push_xfer(t0, vec[v].b);
      wait_drain(60);
      check_b(vec[v].b);
      check("busy_cycles", busy_cnt, 16);
      check("done_count", done_cnt, 1);
    end

    // Reset during CALC of pair 1 abandons the transfer
    mema = vec[0].a;
    clear_b();
    pulse_start(t0);
    push_xfer(t0, vec[0].b);
    while (cyc < t0 + 7) @(negedge clock);
    check("busy_before_reset", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_WEB", WEB, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_AddrB", AddrB, 2'd0);
    check("midrst_DataInB", DataInB, 8'h00);
    wq.delete();
    dq.delete();
    @(negedge clock);
    check("midrst_b0_written", memb[0], 8'hFF);
    check("midrst_b1_unwritten", memb[1], 8'hAA);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    clear_b();
    busy_cnt = 0;
    done_cnt = 0;
    pulse_start(t0);
    push_xfer(t0, vec[0].b);
    wait_drain(60);
    check_b(vec[0].b);
    check("redo_done_count", done_cnt, 1);

    // start during RD1 of pair 2 is ignored
    mema = vec[2].a;
    clear_b();
    busy_cnt = 0;
    done_cnt = 0;
    pulse_start(t0);
    push_xfer(t0, vec[2].b);
    while (cyc < t0 + 10) @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_drain(60);
    repeat (5) @(negedge clock);
    check("ignored_busy_low", busy, 1'b0);
    check("ignored_busy_cycles", busy_cnt, 16);
    check("ignored_done_count", done_cnt, 1);
    check_b(vec[2].b);

    // start held high: two back-to-back transfers
    mema = vec[3].a;
    clear_b();
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    t0 = cyc - 1;
    push_xfer(t0, vec[3].b);
    push_xfer(t0 + 18, vec[3].b);
    while (cyc < t0 + 35) @(negedge clock);
    start = 1'b0;
    wait_drain(80);
    repeat (5) @(negedge clock);
    check("b2b_done_count", done_cnt, 2);
    check("b2b_busy_cycles", busy_cnt, 32);
    check_b(vec[3].b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
